// File: rtl/l2_arbiter.sv
// -----------------------------------------------------------------------------
// l2_arbiter
//   Shares the single unified L2 port between the L1 instruction cache (reads
//   only) and the L1 data cache (reads and write-backs). One requester is
//   granted at a time. Its command is latched on the grant edge and held stable
//   at the L2 until l2_mem_resp. The response is routed back in the same cycle.
//   One RELEASE cycle follows, so the L2 controller sees its request drop before
//   the next transaction starts. Ties are broken round-robin.
//
// Handshake: L1 requests are levels held until their resp pulse. The L2 request
//   (l2_mem_read / l2_mem_write) is a level held through SERVE_x. l2_mem_resp is
//   a one-cycle completion pulse. It is honoured only in SERVE_x and ignored in
//   IDLE and RELEASE.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   i_mem_read, i_mem_addr          I-cache request
//   i_mem_resp, i_mem_rdata         I-cache response (rdata gated by resp)
//   d_mem_read, d_mem_write,
//   d_mem_addr, d_mem_wdata         D-cache request
//   d_mem_resp, d_mem_rdata         D-cache response (rdata gated by resp)
//   l2_mem_read, l2_mem_write,
//   l2_mem_addr, l2_mem_wdata       registered command to L2
//   l2_mem_resp, l2_mem_rdata       L2 completion
//   busy                            high whenever not IDLE
// -----------------------------------------------------------------------------
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              i_mem_resp,
  output logic [LINE_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic              d_mem_resp,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              l2_mem_read,
  output logic              l2_mem_write,
  output logic [ADDR_W-1:0] l2_mem_addr,
  output logic [LINE_W-1:0] l2_mem_wdata,
  input  logic              l2_mem_resp,
  input  logic [LINE_W-1:0] l2_mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t            state;
  state_t            state_next;
  logic              last_d;     // 1: most recent grant went to the D-cache
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              req_i;
  logic              req_d;
  logic              grant_i;
  logic              grant_d;
  logic              serving;

  assign req_i = i_mem_read;
  assign req_d = d_mem_read | d_mem_write;

  // On a tie, the requester that did not win last time is granted.
  assign grant_i = (state == IDLE) && req_i && (!req_d || last_d);
  assign grant_d = (state == IDLE) && req_d && !grant_i;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_next = SERVE_I;
        else if (grant_d) state_next = SERVE_D;
      end
      SERVE_I: if (l2_mem_resp) state_next = RELEASE;
      SERVE_D: if (l2_mem_resp) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        last_d   <= 1'b0;
        op_write <= 1'b0;
        addr_q   <= i_mem_addr;
        wdata_q  <= '0;
      end else if (grant_d) begin
        last_d   <= 1'b1;
        op_write <= d_mem_write;   // write-back wins if read and write are both set
        addr_q   <= d_mem_addr;
        wdata_q  <= d_mem_wdata;
      end
    end
  end

  assign serving      = (state == SERVE_I) || (state == SERVE_D);
  assign l2_mem_read  = serving && !op_write;
  assign l2_mem_write = serving && op_write;
  assign l2_mem_addr  = addr_q;
  assign l2_mem_wdata = wdata_q;

  assign i_mem_resp  = (state == SERVE_I) && l2_mem_resp;
  assign d_mem_resp  = (state == SERVE_D) && l2_mem_resp;
  assign i_mem_rdata = i_mem_resp ? l2_mem_rdata : '0;
  assign d_mem_rdata = d_mem_resp ? l2_mem_rdata : '0;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_l2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_arbiter
//   Directed bench for l2_arbiter. A transaction-level model tracks the current
//   L2 transaction, whether a release gap is pending, and who won last. Every
//   falling edge, one compare process checks all DUT outputs against that model.
//   The main sequence adds literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_l2_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_mem_read = 1'b0;
  logic [ADDR_W-1:0] i_mem_addr = '0;
  logic              i_mem_resp;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              d_mem_read = 1'b0;
  logic              d_mem_write = 1'b0;
  logic [ADDR_W-1:0] d_mem_addr = '0;
  logic [LINE_W-1:0] d_mem_wdata = '0;
  logic              d_mem_resp;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              l2_mem_read;
  logic              l2_mem_write;
  logic [ADDR_W-1:0] l2_mem_addr;
  logic [LINE_W-1:0] l2_mem_wdata;
  logic              l2_mem_resp = 1'b0;
  logic [LINE_W-1:0] l2_mem_rdata = '0;
  logic              busy;

  int n_vec = 0;
  int n_fail = 0;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
    .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
    .l2_mem_addr(l2_mem_addr), .l2_mem_wdata(l2_mem_wdata),
    .l2_mem_resp(l2_mem_resp), .l2_mem_rdata(l2_mem_rdata),
    .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_active: a transaction owns the L2; m_who: 0=I 1=D; m_gap: release cycle pending.
  logic              m_active, m_who, m_write, m_gap, m_last_d;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;

  task automatic model_reset();
    m_active = 1'b0; m_who = 1'b0; m_write = 1'b0; m_gap = 1'b0;
    m_last_d = 1'b1; m_addr = '0; m_wdata = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    logic ri, rd, ir, dr;
    if (!rst_n) model_reset();
    ir = m_active && !m_who && l2_mem_resp;
    dr = m_active &&  m_who && l2_mem_resp;
    chk("busy",        {127'd0, busy},         {127'd0, m_active | m_gap});
    chk("l2_read",     {127'd0, l2_mem_read},  {127'd0, m_active & !m_write});
    chk("l2_write",    {127'd0, l2_mem_write}, {127'd0, m_active & m_write});
    chk("l2_addr",     {112'd0, l2_mem_addr},  {112'd0, m_addr});
    chk("l2_wdata",    l2_mem_wdata,           m_wdata);
    chk("i_resp",      {127'd0, i_mem_resp},   {127'd0, ir});
    chk("d_resp",      {127'd0, d_mem_resp},   {127'd0, dr});
    chk("i_rdata",     i_mem_rdata,            ir ? l2_mem_rdata : '0);
    chk("d_rdata",     d_mem_rdata,            dr ? l2_mem_rdata : '0);
    // Advance the model to what the coming rising edge must produce.
    if (rst_n) begin
      if (m_active) begin
        if (l2_mem_resp) begin m_active = 1'b0; m_gap = 1'b1; end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else begin
        ri = i_mem_read;
        rd = d_mem_read | d_mem_write;
        if (ri && (!rd || m_last_d)) begin
          m_active = 1'b1; m_who = 1'b0; m_last_d = 1'b0;
          m_write = 1'b0; m_addr = i_mem_addr; m_wdata = '0;
        end else if (rd) begin
          m_active = 1'b1; m_who = 1'b1; m_last_d = 1'b1;
          m_write = d_mem_write; m_addr = d_mem_addr; m_wdata = d_mem_wdata;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Wait for an L2 request, capture its command, respond after 'delay' cycles,
  // report which L1 got the response and drop that requester.
  task automatic serve(input int delay, input logic [LINE_W-1:0] rdata,
                       output logic [ADDR_W-1:0] q_addr, output logic q_wr,
                       output logic [LINE_W-1:0] q_wdata,
                       output logic got_i, output logic got_d,
                       output logic [LINE_W-1:0] got_rdata);
    int waited = 0;
    got_i = 1'b0; got_d = 1'b0; got_rdata = '0;
    q_addr = '0; q_wr = 1'b0; q_wdata = '0;
    while (!(l2_mem_read || l2_mem_write) && waited < 40) begin
      cyc(1);
      waited++;
    end
    if (!(l2_mem_read || l2_mem_write)) begin
      n_vec++; n_fail++;
      $display("FAIL serve_wait: no L2 request within 40 cycles at %0t", $time);
      return;
    end
    q_addr = l2_mem_addr; q_wr = l2_mem_write; q_wdata = l2_mem_wdata;
    if (delay > 1) cyc(delay - 1);
    l2_mem_resp = 1'b1;
    l2_mem_rdata = rdata;
    #1;
    got_i = i_mem_resp; got_d = d_mem_resp;
    got_rdata = i_mem_resp ? i_mem_rdata : d_mem_rdata;
    cyc(1);
    l2_mem_resp = 1'b0;
    l2_mem_rdata = '0;
    if (got_i) i_mem_read = 1'b0;
    if (got_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [ADDR_W-1:0] qa;
    logic              qw, gi, gd;
    logic [LINE_W-1:0] qd, gr;
    logic [LINE_W-1:0] line_a5, line_wb;
    line_a5 = {16{8'hA5}};
    line_wb = {4{32'hDEADBEEF}};

    // 1 reset with requests driven
    i_mem_read = 1'b1; i_mem_addr = 16'h1111;
    d_mem_write = 1'b1; d_mem_addr = 16'h2222; d_mem_wdata = line_wb;
    cyc(3);
    chk("rst_busy",  {127'd0, busy}, 128'd0);
    chk("rst_l2req", {126'd0, l2_mem_read, l2_mem_write}, 128'd0);
    chk("rst_addr",  {112'd0, l2_mem_addr}, 128'd0);
    i_mem_read = 1'b0; d_mem_write = 1'b0;
    rst_n = 1'b1;
    cyc(3);
    chk("idle_busy", {127'd0, busy}, 128'd0);

    // 2 I read alone
    i_mem_read = 1'b1; i_mem_addr = 16'h1230;
    cyc(1);
    chk("t2_l2read", {127'd0, l2_mem_read}, 128'd1);
    chk("t2_addr",   {112'd0, l2_mem_addr}, 128'h1230);
    serve(5, line_a5, qa, qw, qd, gi, gd, gr);
    chk("t2_iresp",  {126'd0, gi, gd}, 128'b10);
    chk("t2_rdata",  gr, line_a5);
    chk("t2_rel",    {125'd0, busy, l2_mem_read, l2_mem_write}, 128'b100);
    cyc(1);
    chk("t2_idle",   {127'd0, busy}, 128'd0);

    // 3 contention from reset: I wins, then alternation I,D,I,D
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    i_mem_read = 1'b1; i_mem_addr = 16'h0040;
    d_mem_write = 1'b1; d_mem_addr = 16'h8000; d_mem_wdata = line_wb;
    for (int k = 0; k < 4; k++) begin
      serve(2 + k, {4{32'h1000_0000 + k}}, qa, qw, qd, gi, gd, gr);
      chk("t3_order", {126'd0, gi, gd}, (k % 2 == 0) ? 128'b10 : 128'b01);
      if (k == 0) chk("t3_iaddr", {112'd0, qa}, 128'h0040);
      if (k == 1) begin
        chk("t3_daddr",  {112'd0, qa}, 128'h8000);
        chk("t3_dwrite", {127'd0, qw}, 128'd1);
        chk("t3_dwdata", qd, line_wb);
      end
      // Re-raise whoever was just served so contention continues.
      if (gi) begin i_mem_read = 1'b1; i_mem_addr = 16'h0100 + 16'(k); end
      if (gd) begin d_mem_write = 1'b1; d_mem_addr = 16'h9000 + 16'(k); end
    end
    i_mem_read = 1'b0; d_mem_write = 1'b0;
    cyc(4);

    // 4 command hold after D read grant
    d_mem_read = 1'b1; d_mem_addr = 16'h2200;
    cyc(1);
    d_mem_addr = 16'h3300; d_mem_read = 1'b0;
    cyc(3);
    chk("t4_addr", {112'd0, l2_mem_addr}, 128'h2200);
    chk("t4_op",   {126'd0, l2_mem_read, l2_mem_write}, 128'b10);
    serve(2, {8{16'hC3C3}}, qa, qw, qd, gi, gd, gr);
    chk("t4_dresp", {126'd0, gi, gd}, 128'b01);
    chk("t4_rdata", gr, {8{16'hC3C3}});

    // 5 stray l2_mem_resp in RELEASE, then in IDLE
    l2_mem_resp = 1'b1; l2_mem_rdata = line_a5; #1;
    chk("t5_rel_resp", {126'd0, i_mem_resp, d_mem_resp}, 128'd0);
    cyc(1);
    chk("t5_rel_exit", {127'd0, busy}, 128'd0);
    #1;
    chk("t5_idle_resp", {126'd0, i_mem_resp, d_mem_resp}, 128'd0);
    cyc(1);
    l2_mem_resp = 1'b0; l2_mem_rdata = '0;
    chk("t5_idle_stay", {127'd0, busy}, 128'd0);
    cyc(2);

    // 6 async reset mid SERVE_D
    d_mem_write = 1'b1; d_mem_addr = 16'h5000; d_mem_wdata = {2{64'h0123_4567_89AB_CDEF}};
    cyc(2);
    chk("t6_write", {127'd0, l2_mem_write}, 128'd1);
    #2;
    rst_n = 1'b0;
    i_mem_read = 1'b1; i_mem_addr = 16'h6000;
    #1;
    chk("t6_drop", {125'd0, busy, l2_mem_read, l2_mem_write}, 128'd0);
    chk("t6_nodresp", {127'd0, d_mem_resp}, 128'd0);
    cyc(2);
    rst_n = 1'b1;
    serve(3, {4{32'h6666_0000}}, qa, qw, qd, gi, gd, gr);
    chk("t6_i_first", {126'd0, gi, gd}, 128'b10);
    chk("t6_i_addr",  {112'd0, qa}, 128'h6000);
    serve(2, '0, qa, qw, qd, gi, gd, gr);
    chk("t6_d_next",  {126'd0, gi, gd}, 128'b01);
    chk("t6_d_addr",  {112'd0, qa}, 128'h5000);
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
